// File: rtl/imem_loader.sv
// Host-link loader: assembles framed big-endian byte streams into 32-bit words,
// writes them into instruction or data memory, and gates the processor reset.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  CMD_INSTR = 8'hA5,
  parameter logic [7:0]  CMD_DATA  = 8'h5A,
  parameter logic [7:0]  CMD_RUN   = 8'hC3,
  parameter logic [7:0]  CMD_HALT  = 8'h3C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              ins_we,
  output logic [31:0]       data,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_we,
  output logic              proc_rst,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SHR_W = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    CNT_LO  = 3'd3,
    CNT_HI  = 3'd4,
    WORD    = 3'd5,
    WRITE   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                tgt_data_q, tgt_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [SHR_W-1:0]    shreg_q, shreg_d;
  logic                proc_rst_q, proc_rst_d;
  logic                err_q, err_d;
  logic                ins_we_q, ins_we_d;
  logic                data_we_q, data_we_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
  logic                accept;

  // Handshake and status decode straight from the state
  assign in_ready = (state_q != WRITE);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready;

  // State and registered-output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tgt_data_q   <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      proc_rst_q   <= 1'b1;
      err_q        <= 1'b0;
      ins_we_q     <= 1'b0;
      data_we_q    <= 1'b0;
      instr_q      <= '0;
      data_q       <= '0;
      instr_addr_q <= '0;
      data_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      tgt_data_q   <= tgt_data_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      proc_rst_q   <= proc_rst_d;
      err_q        <= err_d;
      ins_we_q     <= ins_we_d;
      data_we_q    <= data_we_d;
      instr_q      <= instr_d;
      data_q       <= data_d;
      instr_addr_q <= instr_addr_d;
      data_addr_q  <= data_addr_d;
    end
  end

  // Frame parser; strobes are set on the 4th-byte edge so they are high during WRITE
  always_comb begin
    state_d      = state_q;
    tgt_data_d   = tgt_data_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    proc_rst_d   = proc_rst_q;
    err_d        = 1'b0;
    ins_we_d     = 1'b0;
    data_we_d    = 1'b0;
    instr_d      = instr_q;
    data_d       = data_q;
    instr_addr_d = instr_addr_q;
    data_addr_d  = data_addr_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (((in_byte == CMD_INSTR) || (in_byte == CMD_DATA)) && proc_rst_q) begin
            tgt_data_d = (in_byte == CMD_DATA);
            state_d    = ADDR_LO;
          end else if (in_byte == CMD_RUN) begin
            proc_rst_d = 1'b0;
          end else if (in_byte == CMD_HALT) begin
            proc_rst_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR_LO: begin
        if (accept) begin
          shreg_d = {shreg_q[SHR_W-9:0], in_byte};
          state_d = ADDR_HI;
        end
      end

      ADDR_HI: begin
        if (accept) begin
          addr_d  = ADDR_W'({in_byte, shreg_q[7:0]});
          state_d = CNT_LO;
        end
      end

      CNT_LO: begin
        if (accept) begin
          cnt_d   = CNT_W'(in_byte);
          state_d = CNT_HI;
        end
      end

      CNT_HI: begin
        if (accept) begin
          cnt_d   = {in_byte, cnt_q[7:0]};
          idx_d   = 2'd0;
          state_d = (cnt_d == '0) ? IDLE : WORD;
        end
      end

      WORD: begin
        if (accept) begin
          shreg_d = {shreg_q[SHR_W-9:0], in_byte};
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = WRITE;
            if (tgt_data_q) begin
              data_we_d   = 1'b1;
              data_d      = {shreg_q, in_byte};
              data_addr_d = addr_q;
            end else begin
              ins_we_d     = 1'b1;
              instr_d      = {shreg_q, in_byte};
              instr_addr_d = addr_q;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? IDLE : WORD;
      end

      default: state_d = IDLE;
    endcase
  end

  assign proc_rst   = proc_rst_q;
  assign err        = err_q;
  assign ins_we     = ins_we_q;
  assign data_we    = data_we_q;
  assign instr      = instr_q;
  assign data       = data_q;
  assign instr_addr = instr_addr_q;
  assign data_addr  = data_addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed frames, write capture on the
// falling edge, and immediate-assertion checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] instr;
  logic [9:0]  instr_addr;
  logic        ins_we;
  logic [31:0] data;
  logic [9:0]  data_addr;
  logic        data_we;
  logic        proc_rst;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;
  int ins_cnt = 0, dat_cnt = 0, err_cnt = 0, stall_cnt = 0;
  int s0;
  logic [31:0] iw_q[$];
  logic [31:0] dw_q[$];
  logic [9:0]  ia_q[$];
  logic [9:0]  da_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .instr      (instr),
    .instr_addr (instr_addr),
    .ins_we     (ins_we),
    .data       (data),
    .data_addr  (data_addr),
    .data_we    (data_we),
    .proc_rst   (proc_rst),
    .busy       (busy),
    .err        (err)
  );

  // Capture every write strobe, error pulse and stall cycle
  always @(negedge clk) begin
    if (rst) begin
      if (ins_we) begin
        ins_cnt++;
        iw_q.push_back(instr);
        ia_q.push_back(instr_addr);
      end
      if (data_we) begin
        dat_cnt++;
        dw_q.push_back(data);
        da_q.push_back(data_addr);
      end
      if (err) err_cnt++;
      if (!in_ready) stall_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Present a byte and return on the falling edge after it transfers
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: observed in_ready=0 expected=1");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_proc_rst", 32'(proc_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ins_we", 32'(ins_we), 32'd0);
    chk("rst_data_we", 32'(data_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr", instr, 32'd0);

    // Single-word instruction load
    send(8'hA5); send(8'h05); send(8'h00); send(8'h01); send(8'h00);
    send(8'h64); send(8'h44); send(8'h00); send(8'h00);
    chk("w1_ins_we", 32'(ins_we), 32'd1);
    chk("w1_instr", instr, 32'h6444_0000);
    chk("w1_addr", 32'(instr_addr), 32'd5);
    chk("w1_busy_write", 32'(busy), 32'd1);
    chk("w1_ready_write", 32'(in_ready), 32'd0);
    idle(1);
    chk("w1_busy_after", 32'(busy), 32'd0);
    chk("w1_we_after", 32'(ins_we), 32'd0);
    idle(2);
    chk("w1_ins_cnt", 32'(ins_cnt), 32'd1);

    // Two words with address wrap 1023 -> 0
    send(8'hA5); send(8'hFF); send(8'h03); send(8'h02); send(8'h00);
    send(8'h11); send(8'h11); send(8'h11); send(8'h11);
    send(8'h22); send(8'h22); send(8'h22); send(8'h22);
    idle(2);
    chk("wrap_ins_cnt", 32'(ins_cnt), 32'd3);
    chk("wrap_addr0", 32'(ia_q[1]), 32'd1023);
    chk("wrap_word0", iw_q[1], 32'h1111_1111);
    chk("wrap_addr1", 32'(ia_q[2]), 32'd0);
    chk("wrap_word1", iw_q[2], 32'h2222_2222);
    chk("wrap_dat_cnt", 32'(dat_cnt), 32'd0);

    // Data memory load
    send(8'h5A); send(8'h10); send(8'h00); send(8'h01); send(8'h00);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    idle(2);
    chk("dat_cnt", 32'(dat_cnt), 32'd1);
    chk("dat_addr", 32'(da_q[0]), 32'd16);
    chk("dat_word", dw_q[0], 32'hDEAD_BEEF);
    chk("dat_ins_cnt", 32'(ins_cnt), 32'd3);
    chk("instr_hold", instr, 32'h2222_2222);

    // Zero-count frame
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    chk("zero_busy", 32'(busy), 32'd0);
    idle(2);
    chk("zero_ins_cnt", 32'(ins_cnt), 32'd3);

    // in_valid held through a 2-word frame: stalls only in WRITE
    s0 = stall_cnt;
    send(8'hA5); send(8'h20); send(8'h00); send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(2);
    chk("bp_stalls", 32'(stall_cnt - s0), 32'd2);
    chk("bp_ins_cnt", 32'(ins_cnt), 32'd5);
    chk("bp_addr0", 32'(ia_q[3]), 32'd32);
    chk("bp_word0", iw_q[3], 32'h0102_0304);
    chk("bp_addr1", 32'(ia_q[4]), 32'd33);
    chk("bp_word1", iw_q[4], 32'h0506_0708);

    // Run gating and rejected commands
    send(8'hC3);
    chk("run_proc_rst", 32'(proc_rst), 32'd0);
    send(8'hA5);
    chk("gate_err", 32'(err), 32'd1);
    chk("gate_busy", 32'(busy), 32'd0);
    idle(1);
    chk("gate_err_clear", 32'(err), 32'd0);
    send(8'hC3);
    chk("run_again_err", 32'(err), 32'd0);
    send(8'h3C);
    chk("halt_proc_rst", 32'(proc_rst), 32'd1);
    send(8'h77);
    chk("bad_cmd_err", 32'(err), 32'd1);
    idle(2);
    chk("err_cnt", 32'(err_cnt), 32'd2);

    // Reset mid-word, then a fresh frame
    send(8'hA5); send(8'h40); send(8'h00); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_proc_rst", 32'(proc_rst), 32'd1);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'hA5); send(8'h50); send(8'h00); send(8'h01); send(8'h00);
    send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    idle(2);
    chk("mid_ins_cnt", 32'(ins_cnt), 32'd6);
    chk("mid_word", iw_q[iw_q.size()-1], 32'hCCDD_EEFF);
    chk("mid_addr", 32'(ia_q[ia_q.size()-1]), 32'h50);
    chk("final_dat_cnt", 32'(dat_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
